// File: rtl/pifo_traffic_gen.sv
// Push/pop traffic generator and pop-order checker for the PIFO SRAM top.
// Each lane is filled to capacity, then drained. Popped ranks are checked for
// min-first order, lane isolation and (in deterministic modes) exact values.
module pifo_traffic_gen #(
  parameter int          PTW           = 16,
  parameter int          LEVEL         = 2,
  parameter int          LANES         = 2,
  parameter int          TREE_NUM      = 2,
  parameter int          TREE_NUM_BITS = (TREE_NUM > 1) ? $clog2(TREE_NUM) : 1,
  parameter int          LANE_STRIDE   = 4096,
  parameter int          POP_LAT       = 1,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                           i_clk,
  input  logic                           i_arst,
  input  logic                           i_start,
  input  logic [1:0]                     i_mode,
  input  logic [LANES-1:0]               i_fifo_full,
  output logic [LANES-1:0]               o_push,
  output logic [LANES*PTW-1:0]           o_push_data,
  output logic [LANES*TREE_NUM_BITS-1:0] o_tree_id,
  output logic [LANES-1:0]               o_pop,
  input  logic [LANES*PTW-1:0]           i_pop_data,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [LANES-1:0]               o_err
);

  localparam int             CAP        = 2**(LEVEL+1) - 2;
  localparam int             CW         = $clog2(CAP + 1);
  localparam logic [CW-1:0]  CAP_C      = CW'(CAP);
  localparam logic [CW-1:0]  CAP_M1     = CW'(CAP - 1);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
  localparam logic [PTW-1:0] OFS_MASK   = PTW'(LANE_STRIDE - 1);
  localparam logic [2:0]     FLUSH_LAST = 3'(POP_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_GAP, S_DRAIN, S_FLUSH, S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [1:0]       mode_reg;
  logic [15:0]      lfsr_reg;
  logic [2:0]       flush_cnt_reg;
  logic             start_ok;
  logic             exact_chk;
  logic [PTW-1:0]   lfsr_ofs;
  logic [LANES-1:0] fill_last;
  logic [LANES-1:0] drain_last;

  // A start request is honoured only when no run is in progress.
  assign start_ok  = i_start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign o_busy    = (state_reg == S_FILL) || (state_reg == S_GAP) ||
                     (state_reg == S_DRAIN) || (state_reg == S_FLUSH);
  assign o_done    = (state_reg == S_DONE);
  // Random mode only guarantees ordering, so exact-value checks are skipped.
  assign exact_chk = (mode_reg != 2'd2);
  assign lfsr_ofs  = PTW'(lfsr_reg) & OFS_MASK;

  // State register.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: phases advance once every lane has finished.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: if (i_start) state_next = S_FILL;
      S_FILL:         if (&fill_last) state_next = S_GAP;
      S_GAP:          state_next = S_DRAIN;
      S_DRAIN:        if (&drain_last) state_next = S_FLUSH;
      S_FLUSH:        if (flush_cnt_reg == FLUSH_LAST) state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  // Run mode capture, flush timer and rank LFSR (advances every FILL cycle).
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      mode_reg      <= 2'd0;
      flush_cnt_reg <= 3'd0;
      lfsr_reg      <= SEED;
    end else begin
      if (start_ok) mode_reg <= i_mode;
      if (state_reg == S_FLUSH) flush_cnt_reg <= flush_cnt_reg + 3'd1;
      else                      flush_cnt_reg <= 3'd0;
      if (state_reg == S_FILL)
        lfsr_reg <= {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam logic [PTW-1:0] BASE = PTW'(LANE_STRIDE * gi);

    logic [CW-1:0]      push_cnt_reg;
    logic [CW-1:0]      pop_cnt_reg;
    logic [CW-1:0]      chk_idx_reg;
    logic [POP_LAT-1:0] vld_reg;
    logic [PTW-1:0]     prev_reg;
    logic               have_prev_reg;
    logic               err_reg;
    logic [PTW-1:0]     push_ofs;
    logic [PTW-1:0]     pop_val;
    logic               out_of_lane;
    logic               bad;

    assign o_tree_id[gi*TREE_NUM_BITS +: TREE_NUM_BITS] = TREE_NUM_BITS'(gi % TREE_NUM);
    assign o_push[gi]     = (state_reg == S_FILL) && (push_cnt_reg < CAP_C) && !i_fifo_full[gi];
    assign o_pop[gi]      = (state_reg == S_DRAIN) && (pop_cnt_reg < CAP_C);
    assign fill_last[gi]  = (push_cnt_reg == CAP_C) || ((push_cnt_reg == CAP_M1) && o_push[gi]);
    assign drain_last[gi] = (pop_cnt_reg == CAP_C) || ((pop_cnt_reg == CAP_M1) && o_pop[gi]);
    assign o_err[gi]      = err_reg;

    // Rank offset within the lane for the current push.
    always_comb begin
      push_ofs = PTW'(push_cnt_reg);
      case (mode_reg)
        2'd1:    push_ofs = PTW'(CAP_M1 - push_cnt_reg);
        2'd2:    push_ofs = lfsr_ofs;
        default: push_ofs = PTW'(push_cnt_reg);
      endcase
    end

    assign o_push_data[gi*PTW +: PTW] = o_push[gi] ? (BASE + push_ofs) : '0;

    // Lane ranges are stride-aligned, so any borrow or high bit means foreign data.
    assign pop_val     = i_pop_data[gi*PTW +: PTW];
    assign out_of_lane = |((pop_val - BASE) & ~OFS_MASK);
    assign bad         = out_of_lane ||
                         (have_prev_reg && (pop_val < prev_reg)) ||
                         (exact_chk && (pop_val != (BASE + PTW'(chk_idx_reg))));

    // Push/pop counters and the delay-matched pop checker.
    always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
        push_cnt_reg  <= '0;
        pop_cnt_reg   <= '0;
        chk_idx_reg   <= '0;
        vld_reg       <= '0;
        prev_reg      <= '0;
        have_prev_reg <= 1'b0;
        err_reg       <= 1'b0;
      end else if (start_ok) begin
        push_cnt_reg  <= '0;
        pop_cnt_reg   <= '0;
        chk_idx_reg   <= '0;
        vld_reg       <= '0;
        have_prev_reg <= 1'b0;
        err_reg       <= 1'b0;
      end else begin
        if (o_push[gi]) push_cnt_reg <= push_cnt_reg + CNT_ONE;
        if (o_pop[gi])  pop_cnt_reg  <= pop_cnt_reg + CNT_ONE;
        vld_reg <= (vld_reg << 1) | POP_LAT'(o_pop[gi]);
        if (vld_reg[POP_LAT-1]) begin
          chk_idx_reg   <= chk_idx_reg + CNT_ONE;
          prev_reg      <= pop_val;
          have_prev_reg <= 1'b1;
          if (bad) err_reg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pifo_traffic_gen.sv
// Bench for pifo_traffic_gen: a table of runs plus randomized backpressure runs,
// checked against a behavioural PIFO (sorted store) and a reference rank model.
module tb_pifo_traffic_gen;

  localparam int          CAP     = 6;
  localparam int          STRIDE  = 4096;
  localparam int          POP_LAT = 1;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic        clk = 1'b0;
  logic        arst;
  logic        start;
  logic [1:0]  mode;
  logic [1:0]  full;
  logic [1:0]  push;
  logic [31:0] push_data;
  logic [1:0]  tree_id;
  logic [1:0]  pop;
  logic [31:0] pop_data;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  always #5 clk = ~clk;

  pifo_traffic_gen #(
    .PTW(16), .LEVEL(2), .LANES(2), .TREE_NUM(2), .TREE_NUM_BITS(1),
    .LANE_STRIDE(STRIDE), .POP_LAT(POP_LAT), .SEED(SEED)
  ) u_dut (
    .i_clk(clk), .i_arst(arst), .i_start(start), .i_mode(mode),
    .i_fifo_full(full), .o_push(push), .o_push_data(push_data),
    .o_tree_id(tree_id), .o_pop(pop), .i_pop_data(pop_data),
    .o_busy(busy), .o_done(done), .o_err(err)
  );

  typedef struct {
    int         mode;
    logic [1:0] bp_mask;
    int         bp_start;
    int         bp_len;
    bit         rand_bp;
    int         fault;       // 0 none, 1 lane0 swaps ranks 2/3, 2 lane1 returns 7
    int         restart_at;  // cycle of an extra i_start pulse while busy (0 = none)
    int         abort_at;    // cycle of a reset pulse (0 = none)
    bit         pre_reset;
    logic [1:0] exp_err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural PIFO and logs.
  int          q_val   [2][16];
  int          q_cnt   [2];
  int          pop_idx [2];
  bit          pend_v  [2];
  logic [15:0] pend_d  [2];
  int          exp_log [2][32];
  int          exp_n   [2];
  int          dut_log [2][32];
  int          dut_n   [2];
  logic [15:0] tb_lfsr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // x^16+x^14+x^13+x^11+1 in right-shifting Galois form.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic [15:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic logic [15:0] exp_rank(input int md, input int l, input int k, input logic [15:0] lf);
    int ofs;
    if (md == 1)      ofs = CAP - 1 - k;
    else if (md == 2) ofs = int'(lf) & (STRIDE - 1);
    else              ofs = k;
    return 16'((STRIDE * l + ofs) % 65536);
  endfunction

  function automatic vec_t mk(input int md, input logic [1:0] bm, input int bs, input int bl,
                              input bit rb, input int ft, input int rs, input int ab,
                              input bit pr, input logic [1:0] ee);
    vec_t v;
    v.mode = md; v.bp_mask = bm; v.bp_start = bs; v.bp_len = bl; v.rand_bp = rb;
    v.fault = ft; v.restart_at = rs; v.abort_at = ab; v.pre_reset = pr; v.exp_err = ee;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_push"}, push, 2'b00);
    check({tag, "_pop"}, pop, 2'b00);
    check({tag, "_push_data"}, push_data, 32'h0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 2'b00);
    check({tag, "_tree_id"}, tree_id, 2'b10);
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst = 1'b1; start = 1'b0; full = 2'b00;
    @(negedge clk);
    arst = 1'b0;
    tb_lfsr = SEED;
  endtask

  // Remove the minimum (or the second minimum when faulting) from a lane's store.
  task automatic model_pop(input int l, input int fault);
    int mi, mi2, val;
    mi = 0;
    for (int i = 1; i < q_cnt[l]; i++) if (q_val[l][i] < q_val[l][mi]) mi = i;
    if (fault == 1 && l == 0 && pop_idx[0] == 2 && q_cnt[l] >= 2) begin
      mi2 = (mi == 0) ? 1 : 0;
      for (int i = 0; i < q_cnt[l]; i++)
        if (i != mi && q_val[l][i] < q_val[l][mi2]) mi2 = i;
      mi = mi2;
    end
    if (q_cnt[l] > 0) begin
      val = q_val[l][mi];
      q_val[l][mi] = q_val[l][q_cnt[l]-1];
      q_cnt[l]--;
    end else begin
      val = 0;
    end
    if (fault == 2 && l == 1 && pop_idx[1] == 0) val = 7;
    pend_d[l] = 16'(val);
    pend_v[l] = 1'b1;
    pop_idx[l]++;
  endtask

  task automatic run_case(input vec_t v, input int id);
    int          n, fill_len, done_n;
    int          tb_cnt [2];
    bit          filling, done_seen, ovl;
    logic [1:0]  f;
    logic [15:0] pv;
    if (v.pre_reset) do_reset();
    for (int l = 0; l < 2; l++) begin
      q_cnt[l] = 0; pop_idx[l] = 0; pend_v[l] = 1'b0;
      exp_n[l] = 0; dut_n[l] = 0; tb_cnt[l] = 0;
    end
    @(negedge clk);
    mode = 2'(v.mode); start = 1'b1; full = 2'b00;
    @(posedge clk);
    n = 0; filling = 1'b1; fill_len = 0; done_seen = 1'b0; done_n = 0; ovl = 1'b0;
    while (!done_seen && n < 200) begin
      @(negedge clk);
      n++;
      start = (v.restart_at == n);
      for (int l = 0; l < 2; l++) begin
        pv = pend_v[l] ? pend_d[l] : 16'($urandom);
        pop_data[l*16 +: 16] = pv;
        pend_v[l] = 1'b0;
      end
      f = 2'b00;
      if (filling) begin
        if (v.rand_bp) f = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
        else if (n >= v.bp_start && n < v.bp_start + v.bp_len) f = v.bp_mask;
        for (int l = 0; l < 2; l++) begin
          if (tb_cnt[l] < CAP && !f[l]) begin
            exp_log[l][exp_n[l]] = int'(exp_rank(v.mode, l, tb_cnt[l], tb_lfsr));
            exp_n[l]++;
            tb_cnt[l]++;
          end
        end
        tb_lfsr = lfsr_step(tb_lfsr);
        if (tb_cnt[0] == CAP && tb_cnt[1] == CAP) begin
          filling = 1'b0;
          fill_len = n;
        end
      end
      full = f;
      #1;
      if (n == 1) begin
        check("start_done_low", done, 1'b0);
        check("start_err_clear", err, 2'b00);
        check("start_busy", busy, 1'b1);
      end
      if (v.abort_at == n) begin
        check("abort_pre_pop", pop, 2'b11);
        #1 arst = 1'b1;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        arst = 1'b0;
        tb_lfsr = SEED;
        $display("run %0d mode %0d aborted at cycle %0d", id, v.mode, n);
        return;
      end
      if (done) begin
        done_seen = 1'b1;
        done_n = n;
      end
      if ((push & pop) != 2'b00) ovl = 1'b1;
      for (int l = 0; l < 2; l++) begin
        if (push[l] && dut_n[l] < 32) begin
          dut_log[l][dut_n[l]] = int'(push_data[l*16 +: 16]);
          dut_n[l]++;
          if (q_cnt[l] < 16) begin
            q_val[l][q_cnt[l]] = int'(push_data[l*16 +: 16]);
            q_cnt[l]++;
          end
        end
        if (pop[l]) model_pop(l, v.fault);
      end
    end
    check("done_reached", done_seen, 1'b1);
    check("start_to_done", done_n, fill_len + CAP + POP_LAT + 2);
    check("push_pop_overlap", ovl, 1'b0);
    check("final_err", err, v.exp_err);
    check("final_busy", busy, 1'b0);
    for (int l = 0; l < 2; l++) begin
      check("push_count", dut_n[l], CAP);
      for (int k = 0; k < CAP; k++)
        check($sformatf("push_l%0d_k%0d", l, k), dut_log[l][k], exp_log[l][k]);
    end
    repeat (2) @(negedge clk);
    full = 2'b00;
    check("done_held", done, 1'b1);
    check("err_sticky", err, v.exp_err);
    $display("run %0d mode %0d cycles %0d (expected %0d) err %b (expected %b)",
             id, v.mode, done_n, fill_len + CAP + POP_LAT + 2, err, v.exp_err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl [11];
    vec_t rv;
    tbl[0]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 2'b00);
    tbl[1]  = mk(1, 2'b00, 0, 0, 0, 0, 0, 0,  0, 2'b00);
    tbl[2]  = mk(0, 2'b10, 3, 3, 0, 0, 0, 0,  0, 2'b00);
    tbl[3]  = mk(3, 2'b00, 0, 0, 0, 0, 5, 0,  0, 2'b00);
    tbl[4]  = mk(0, 2'b00, 0, 0, 0, 1, 0, 0,  0, 2'b01);
    tbl[5]  = mk(0, 2'b00, 0, 0, 0, 2, 0, 0,  0, 2'b10);
    tbl[6]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 10, 0, 2'b00);
    tbl[7]  = mk(0, 2'b00, 0, 0, 0, 0, 0, 0,  0, 2'b00);
    tbl[8]  = mk(2, 2'b00, 0, 0, 0, 0, 0, 0,  1, 2'b00);
    tbl[9]  = mk(2, 2'b00, 0, 0, 0, 0, 0, 0,  1, 2'b00);
    tbl[10] = mk(1, 2'b11, 1, 2, 0, 0, 0, 0,  0, 2'b00);

    arst = 1'b1; start = 1'b0; mode = 2'd0; full = 2'b00; pop_data = 32'h0;
    tb_lfsr = SEED;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    arst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_tree_id", tree_id, 2'b10);

    for (int i = 0; i < 11; i++) run_case(tbl[i], i);

    for (int i = 0; i < 6; i++) begin
      rv = mk(int'($urandom_range(0, 3)), 2'b00, 0, 0, 1, 0, 0, 0, 0, 2'b00);
      run_case(rv, 100 + i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pifo_traffic_gen.md
# pifo_traffic_gen

Synthesizable multi-lane push/pop traffic generator and order checker for the PIFO SRAM top. It fills every lane to capacity and then drains it, with tree IDs, rank patterns and lane count all parametrised. It honours per-lane task-FIFO backpressure and checks popped ranks for min-first order and lane isolation. It sits between a control register block and the PIFO top, for on-chip bring-up and regression.

## Interface
Parameters:
- PTW, 16, rank/data width
- LEVEL, 2, PIFO tree levels; sets capacity CAP = 2**(LEVEL+1)-2 per lane
- LANES, 2, independent push/pop channels
- TREE_NUM, 2, trees; lane l drives tree_id = l mod TREE_NUM
- TREE_NUM_BITS, $clog2(TREE_NUM), tree-ID width (minimum 1)
- LANE_STRIDE, 4096, rank offset per lane; power of two; LANE_STRIDE*LANES <= 2**PTW
- POP_LAT, 1, cycles from o_pop to valid i_pop_data (1..4)
- SEED, 16'hACE1, LFSR reset value (non-zero)

Ports:
- i_clk  in  1  clock; all state on rising edge
- i_arst  in  1  asynchronous, active-high reset
- i_start  in  1  start a run; sampled only in IDLE/DONE
- i_mode  in  2  0 ascending, 1 descending, 2 LFSR-random, 3 treated as 0
- i_fifo_full  in  LANES  per-lane backpressure; blocks push that cycle
- o_push  out  LANES  per-lane push strobe
- o_push_data  out  LANES*PTW  lane l at [l*PTW +: PTW]
- o_tree_id  out  LANES*TREE_NUM_BITS  lane l at [l*TREE_NUM_BITS +: TREE_NUM_BITS]
- o_pop  out  LANES  per-lane pop strobe
- i_pop_data  in  LANES*PTW  popped rank, lane-packed like o_push_data
- o_busy  out  1  high in FILL/GAP/DRAIN/FLUSH
- o_done  out  1  level; high in DONE
- o_err  out  LANES  sticky per-lane check failure; cleared on accepted i_start

## Operation
- FSM: IDLE -> FILL (i_start) -> GAP (every lane pushed CAP) -> DRAIN (1 cycle later) -> FLUSH (every lane popped CAP) -> DONE (after POP_LAT cycles) -> FILL (i_start).
- Per lane: push counter k and pop counter p, each 0..CAP, with width $clog2(CAP+1).
- FILL, lane l:
  - o_push[l] = (k<CAP) & ~i_fifo_full[l]; k increments only when pushed.
  - A finished lane idles while the others complete.
- Push data, computed mod 2**PTW:
  - mode 0: LANE_STRIDE*l + k
  - mode 1: LANE_STRIDE*l + (CAP-1-k)
  - mode 2: LANE_STRIDE*l + (lfsr & (LANE_STRIDE-1))
- LFSR: 16-bit Galois, taps 16,14,13,11. Advances once per cycle in FILL. All lanes use the same value that cycle.
- o_tree_id is constant per lane, driven in all states. o_push_data is 0 when o_push is low.
- DRAIN: o_pop[l] = (p<CAP); no backpressure on pops.
- Checker: each pop is delay-matched by a POP_LAT-deep valid shift register per lane. On each valid sample v, set o_err[l] if any of these holds:
  - v outside [LANE_STRIDE*l, LANE_STRIDE*(l+1)-1]
  - v < previous valid sample of the same run (order violation)
  - mode 0 or 1 and v != LANE_STRIDE*l + (pop index)
- o_err is never cleared by DONE. An i_start seen while busy is ignored.

## Timing
- Reset (async assert, sync release): state IDLE; o_push, o_pop, o_push_data, o_busy, o_done, o_err all 0; o_tree_id = lane constants; counters 0; LFSR = SEED.
- Reset mid-run aborts immediately; outputs reach reset values without a clock.
- i_start high at edge t0 (from IDLE/DONE): FILL at t0+1, first o_push high in cycle t0+1, o_busy high from t0+1.
- No backpressure: push high for CAP cycles, 1 all-low GAP cycle, pop high for CAP cycles, POP_LAT FLUSH cycles, then o_done high. Total start-to-done = 2*CAP + 2 + POP_LAT edges.
- i_fifo_full sampled combinationally in the same cycle; each full cycle extends that lane by one cycle.
- o_done falls, and o_err clears, the cycle after an accepted i_start.
- o_push and o_pop are never high in the same cycle on any lane.

## Test plan
- Mode 0, LANES=2, LEVEL=2, ideal PIFO model, POP_LAT=1 -> lane 0 pushes 0..5, lane 1 pushes 4096..4101, tree_id 0/1; o_done 15 edges after start; o_err=00.
- Mode 1 -> pushes 5..0 and 4101..4096; pops ascending; o_err=00.
- Mode 0 with i_fifo_full[1] high for 3 cycles mid-FILL -> lane 1 push stalls 3 cycles, still exactly 6 pushes; GAP entered 3 cycles later; o_err=00.
- Faulty model returns 3 before 2 on lane 0 -> o_err=01 sticky through DONE; cleared by the next i_start.
- Lane 1 returns 7 (lane-0 range) -> o_err[1]=1.
- i_arst pulse during DRAIN -> all outputs 0 asynchronously, FSM in IDLE; a fresh start completes cleanly; mode 2 run with SEED reproduces an identical push sequence.
